// File: rtl/regfile_write_arbiter_if.sv
// Multi-port register-file write request bundle: per-port valid/address/data from the
// writeback side and per-port ready back from the arbiter.
interface regfile_write_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [N_PORTS-1:0]        wr_valid;
    logic [N_PORTS*ADDR_W-1:0] wr_addr;
    logic [N_PORTS*DATA_W-1:0] wr_data;
    logic [N_PORTS-1:0]        wr_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Multi-port register-file write front-end: arbitrates same-register conflicts, decodes
// winners to one-hot enables and registers enables/data one cycle later. Register 0 is never written.
module regfile_write_arbiter #(
    parameter int N_REGS   = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int N_PORTS  = 2,
    parameter int ARB_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic                      clock,
    input  logic                      ctrl_reset,
    regfile_write_arbiter_if.slave    wr,
    output logic [N_REGS-1:0]         reg_we,
    output logic [N_REGS*DATA_W-1:0]  reg_wdata,
    output logic [CNT_W-1:0]          conflict_count
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [ADDR_W-1:0]        addr [N_PORTS];
    logic [DATA_W-1:0]        data [N_PORTS];
    logic [N_PORTS-1:0]       lost;
    logic [N_PORTS-1:0]       grant;
    logic                     conflict;

    logic [N_REGS-1:0]        reg_we_q, reg_we_d;
    logic [N_REGS*DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic [CNT_W-1:0]         conflict_count_q;
    logic [PTR_W-1:0]         rr_ptr_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (int'(p) >= N_PORTS - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // Round-robin ranks ports by cyclic distance from rr_ptr; smaller distance wins.
    function automatic logic beats(input int q, input int p, input logic [PTR_W-1:0] ptr);
        int dq;
        int dp;
        dq = (q - int'(ptr) + N_PORTS) % N_PORTS;
        dp = (p - int'(ptr) + N_PORTS) % N_PORTS;
        if (ARB_MODE == 0) begin
            return q < p;
        end
        return dq < dp;
    endfunction

    for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
        assign addr[g] = wr.wr_addr[g*ADDR_W +: ADDR_W];
        assign data[g] = wr.wr_data[g*DATA_W +: DATA_W];
    end

    always_comb begin
        lost = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            for (int q = 0; q < N_PORTS; q++) begin
                if (q != p && wr.wr_valid[p] && wr.wr_valid[q] && addr[p] != '0 &&
                    addr[q] == addr[p] && beats(q, p, rr_ptr_q)) begin
                    lost[p] = 1'b1;
                end
            end
        end
    end

    // Ready depends only on valid/address/pointer and is forced low during reset.
    assign grant       = wr.wr_valid & ~lost & {N_PORTS{~ctrl_reset}};
    assign wr.wr_ready = grant;
    assign conflict    = |lost;

    always_comb begin
        reg_we_d    = '0;
        reg_wdata_d = reg_wdata_q;
        for (int p = 0; p < N_PORTS; p++) begin
            if (grant[p] && addr[p] != '0) begin
                reg_we_d[addr[p]] = 1'b1;
                reg_wdata_d[int'(addr[p])*DATA_W +: DATA_W] = data[p];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            reg_we_q         <= '0;
            reg_wdata_q      <= '0;
            conflict_count_q <= '0;
            rr_ptr_q         <= '0;
        end else begin
            reg_we_q    <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
            if (conflict) begin
                conflict_count_q <= sat_inc(conflict_count_q);
                rr_ptr_q         <= ptr_next(rr_ptr_q);
            end
        end
    end

    assign reg_we         = reg_we_q;
    assign reg_wdata      = reg_wdata_q;
    assign conflict_count = conflict_count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: a fixed-priority instance (2-bit conflict counter) and a round-robin instance
// share clock and reset; expected register-side outputs are queued at drive time and checked a cycle later.
module tb_regfile_write_arbiter;

    logic clock;
    logic rst;

    regfile_write_arbiter_if #(.N_PORTS(2), .ADDR_W(5), .DATA_W(32)) if0 ();
    regfile_write_arbiter_if #(.N_PORTS(2), .ADDR_W(5), .DATA_W(32)) if1 ();

    logic [31:0]    we0, we1;
    logic [1023:0]  wd0, wd1;
    logic [1:0]     cc0;
    logic [15:0]    cc1;

    regfile_write_arbiter #(.N_REGS(32), .ADDR_W(5), .DATA_W(32), .N_PORTS(2),
                            .ARB_MODE(0), .CNT_W(2)) dut0 (
        .clock(clock), .ctrl_reset(rst), .wr(if0.slave),
        .reg_we(we0), .reg_wdata(wd0), .conflict_count(cc0)
    );

    regfile_write_arbiter #(.N_REGS(32), .ADDR_W(5), .DATA_W(32), .N_PORTS(2),
                            .ARB_MODE(1), .CNT_W(16)) dut1 (
        .clock(clock), .ctrl_reset(rst), .wr(if1.slave),
        .reg_we(we1), .reg_wdata(wd1), .conflict_count(cc1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          inst;
        logic [31:0] we;
        int          a;
        logic [31:0] d;
        int          b;
        logic [31:0] e;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input int inst, input logic [31:0] we, input int a,
                              input logic [31:0] d, input int b, input logic [31:0] e);
        exp_t x;
        x.inst = inst; x.we = we; x.a = a; x.d = d; x.b = b; x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        exp_t x;
        @(posedge clock);
        #1;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            if (x.inst == 0) begin
                check_eq("we0", 64'(we0), 64'(x.we));
                if (x.a >= 0) check_eq("wdata0_a", 64'(wd0[x.a*32 +: 32]), 64'(x.d));
                if (x.b >= 0) check_eq("wdata0_b", 64'(wd0[x.b*32 +: 32]), 64'(x.e));
            end else begin
                check_eq("we1", 64'(we1), 64'(x.we));
                if (x.a >= 0) check_eq("wdata1_a", 64'(wd1[x.a*32 +: 32]), 64'(x.d));
                if (x.b >= 0) check_eq("wdata1_b", 64'(wd1[x.b*32 +: 32]), 64'(x.e));
            end
        end
    endtask

    task automatic drv0(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
        if0.wr_valid = v;
        if0.wr_addr  = {a1, a0};
        if0.wr_data  = {d1, d0};
    endtask

    task automatic drv1(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
        if1.wr_valid = v;
        if1.wr_addr  = {a1, a0};
        if1.wr_data  = {d1, d0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0] rr_exp [4];
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

        // Reset held two cycles with requests present
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drv0(2'b11, 5'd5, 32'h1, 5'd6, 32'h2);
            drv1(2'b11, 5'd5, 32'h1, 5'd6, 32'h2);
            #1;
            check_eq("rst_ready0", 64'(if0.wr_ready), 64'h0);
            check_eq("rst_ready1", 64'(if1.wr_ready), 64'h0);
            expect_out(0, 32'h0, -1, 32'h0, -1, 32'h0);
            tick();
            check_eq("rst_cc0", 64'(cc0), 64'h0);
        end
        rst = 1'b0;
        drv0(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        drv1(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();

        // Single write
        drv0(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        #1;
        check_eq("single_ready", 64'(if0.wr_ready), 64'h1);
        expect_out(0, 32'h20, 5, 32'hDEADBEEF, -1, 32'h0);
        tick();
        drv0(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        expect_out(0, 32'h0, 5, 32'hDEADBEEF, -1, 32'h0);
        tick();

        // Parallel writes to distinct registers
        drv0(2'b11, 5'd3, 32'h1, 5'd7, 32'h2);
        #1;
        check_eq("par_ready", 64'(if0.wr_ready), 64'h3);
        expect_out(0, 32'h88, 3, 32'h1, 7, 32'h2);
        tick();
        check_eq("par_cc", 64'(cc0), 64'h0);

        // Fixed-priority conflict on register 9
        drv0(2'b11, 5'd9, 32'hAAAA0000, 5'd9, 32'hBBBB0000);
        #1;
        check_eq("fix_ready1", 64'(if0.wr_ready), 64'h1);
        expect_out(0, 32'h200, 9, 32'hAAAA0000, -1, 32'h0);
        tick();
        drv0(2'b10, 5'd9, 32'hAAAA0000, 5'd9, 32'hBBBB0000);
        #1;
        check_eq("fix_ready2", 64'(if0.wr_ready), 64'h2);
        expect_out(0, 32'h200, 9, 32'hBBBB0000, -1, 32'h0);
        tick();
        drv0(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        check_eq("fix_cc", 64'(cc0), 64'h1);
        expect_out(0, 32'h0, 9, 32'hBBBB0000, -1, 32'h0);
        tick();

        // Round-robin conflict on register 4, both ports re-presenting every cycle
        for (int i = 0; i < 4; i++) begin
            drv1(2'b11, 5'd4, 32'h10, 5'd4, 32'h11);
            #1;
            check_eq($sformatf("rr_ready%0d", i), 64'(if1.wr_ready), 64'(rr_exp[i]));
            expect_out(1, 32'h10, 4, (rr_exp[i] == 2'b01) ? 32'h10 : 32'h11, -1, 32'h0);
            tick();
        end
        drv1(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        check_eq("rr_cc", 64'(cc1), 64'h4);
        tick();

        // Register 0 write completes but never enables
        drv0(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0);
        #1;
        check_eq("r0_ready", 64'(if0.wr_ready), 64'h1);
        expect_out(0, 32'h0, 0, 32'h0, -1, 32'h0);
        tick();

        // Five more conflict cycles saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            drv0(2'b11, 5'd1, 32'h100 + 32'(i), 5'd1, 32'h200);
            #1;
            check_eq($sformatf("sat_ready%0d", i), 64'(if0.wr_ready), 64'h1);
            expect_out(0, 32'h2, 1, 32'h100 + 32'(i), -1, 32'h0);
            tick();
        end
        check_eq("sat_cc", 64'(cc0), 64'h3);

        // Reset while the losing port is still pending
        drv0(2'b11, 5'd2, 32'h55, 5'd2, 32'h66);
        #1;
        check_eq("mid_ready", 64'(if0.wr_ready), 64'h1);
        expect_out(0, 32'h4, 2, 32'h55, -1, 32'h0);
        tick();
        drv0(2'b10, 5'd2, 32'h55, 5'd2, 32'h66);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ready", 64'(if0.wr_ready), 64'h0);
        expect_out(0, 32'h0, 2, 32'h0, -1, 32'h0);
        tick();
        check_eq("mid_rst_cc", 64'(cc0), 64'h0);
        rst = 1'b0;
        drv0(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        expect_out(0, 32'h0, 2, 32'h0, -1, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
